// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges stage stall requests, sequences exception/ERET flushes, keeps stall/flush stats and a stall watchdog.
module pipe_ctrl #(
  parameter logic [31:0] EXC_BASE = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE = 32'h0000_000e,
  parameter int STALL_TIMEOUT = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic [31:0]      excepttype,
  input  logic [31:0]      cp0_epc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
  localparam int WD_W = $clog2(STALL_TIMEOUT + 1);
  state_t state;
  logic [WD_W-1:0] wd_cnt;
  logic take, stalled, any_req;
  always_comb begin
    any_req = stallreq_id | stallreq_ex | stallreq_mem;
    stall = (state == FLUSH || rst) ? 6'b000000 :
            stallreq_mem ? 6'b011111 :
            stallreq_ex  ? 6'b001111 :
            stallreq_id  ? 6'b000111 : 6'b000000;
    stalled = |stall;
    take = (excepttype != 32'd0) && (state != FLUSH);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      flush <= 1'b0;
      new_pc <= 32'd0;
      stall_timeout <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      wd_cnt <= '0;
    end else begin
      state <= take ? FLUSH : any_req ? STALL : RUN;
      flush <= take;
      if (take) new_pc <= (excepttype == ERET_CODE) ? cp0_epc : EXC_BASE;
      if (take && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
      if (stalled && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      // count stops at the threshold so it never wraps on very long stalls
      wd_cnt <= !stalled ? '0 : (wd_cnt == WD_W'(STALL_TIMEOUT)) ? wd_cnt : wd_cnt + 1'b1;
      if (stalled && wd_cnt == WD_W'(STALL_TIMEOUT - 1)) stall_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: randomized + directed checks of pipe_ctrl against a cycle-level behavioural model.
module tb_pipe_ctrl;
  logic clk = 0, rst = 1;
  logic stallreq_id = 0, stallreq_ex = 0, stallreq_mem = 0;
  logic [31:0] excepttype = 0, cp0_epc = 0;
  logic [5:0] stall, stall_s;
  logic flush, flush_s, stall_timeout, stall_timeout_s;
  logic [31:0] new_pc, new_pc_s, stall_cnt, flush_cnt;
  logic [3:0] stall_cnt_s, flush_cnt_s;
  int n_vec = 0, n_bad = 0;
  bit m_flush, m_to;
  logic [31:0] m_pc;
  longint m_sc, m_fc, m_wd;
  always #5 clk = ~clk;
  pipe_ctrl dut (.clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .stallreq_mem(stallreq_mem), .excepttype(excepttype), .cp0_epc(cp0_epc), .stall(stall),
    .flush(flush), .new_pc(new_pc), .stall_timeout(stall_timeout), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt));
  pipe_ctrl #(.CNT_W(4)) dut_s (.clk(clk), .rst(rst), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem), .excepttype(excepttype),
    .cp0_epc(cp0_epc), .stall(stall_s), .flush(flush_s), .new_pc(new_pc_s),
    .stall_timeout(stall_timeout_s), .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask
  function automatic logic [5:0] exp_stall();
    if (m_flush || rst) return 6'h00;
    if (stallreq_mem) return 6'h1f;
    if (stallreq_ex) return 6'h0f;
    if (stallreq_id) return 6'h07;
    return 6'h00;
  endfunction
  function automatic logic [31:0] sat(input longint v, input longint mx);
    return 32'(v > mx ? mx : v);
  endfunction
  // check every output for the current inputs, then advance the model over the edge
  task automatic cyc();
    logic [5:0] es;
    bit take;
    @(negedge clk);
    es = exp_stall();
    chk("stall", 32'(stall), 32'(es));
    chk("flush", 32'(flush), 32'(m_flush));
    chk("new_pc", new_pc, m_pc);
    chk("timeout", 32'(stall_timeout), 32'(m_to));
    chk("stall_cnt", stall_cnt, sat(m_sc, 64'hffff_ffff));
    chk("flush_cnt", flush_cnt, sat(m_fc, 64'hffff_ffff));
    chk("stall_s", 32'(stall_s), 32'(es));
    chk("stall_cnt4", 32'(stall_cnt_s), sat(m_sc, 15));
    chk("flush_cnt4", 32'(flush_cnt_s), sat(m_fc, 15));
    @(posedge clk);
    if (rst) begin
      m_flush = 0; m_to = 0; m_pc = 0; m_sc = 0; m_fc = 0; m_wd = 0;
    end else begin
      take = (excepttype != 0) && !m_flush;
      m_sc += (es != 0);
      m_wd = (es != 0) ? m_wd + 1 : 0;
      if (m_wd >= 64) m_to = 1;
      if (take) begin
        m_pc = (excepttype == 32'he) ? cp0_epc : 32'h20;
        m_fc++;
      end
      m_flush = take;
    end
    #1;
  endtask
  task automatic drive(input bit r, input bit id, input bit ex, input bit mem, input logic [31:0] et,
                       input logic [31:0] epc, input int n);
    rst = r; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem; excepttype = et; cp0_epc = epc;
    for (int i = 0; i < n; i++) cyc();
  endtask
  initial begin
    drive(1, 0, 0, 1, 0, 0, 3);
    drive(0, 1, 0, 0, 0, 0, 3);
    drive(0, 1, 1, 0, 0, 0, 1);
    chk("t2_stall_cnt", stall_cnt, 32'd4);
    drive(0, 0, 0, 0, 0, 0, 2);
    drive(0, 0, 0, 0, 32'h8, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 2);
    chk("t3_flush_cnt", flush_cnt, 32'd1);
    drive(0, 0, 1, 0, 32'he, 32'h1234, 1);
    drive(0, 0, 1, 0, 0, 32'h1234, 2);
    chk("t4_new_pc", new_pc, 32'h1234);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 32'h4, 0, 3);
    drive(0, 0, 0, 0, 0, 0, 2);
    chk("t5_flush_cnt", flush_cnt, 32'd2);
    drive(0, 0, 0, 1, 0, 0, 64);
    drive(0, 0, 0, 0, 0, 0, 2);
    chk("t6_timeout", 32'(stall_timeout), 32'd1);
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(0, 1, 1, 1, 0, 0, 63);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("t6_no_timeout", 32'(stall_timeout), 32'd0);
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0,
            ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 1) ? 32'he : 32'($urandom_range(1, 31))) : 32'd0,
            $urandom, ($urandom_range(0, 49) == 0) ? 80 : 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
